// File: rtl/step_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_core_pkg
// Description : Shared definitions for the step_core processor: opcode
//               values, instruction field positions, FSM state encoding
//               and register-file geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package step_core_pkg;

    // Register file geometry
    localparam int unsigned c_NUM_REGS = 8;
    localparam int unsigned c_REG_AW   = 3;

    // Instruction field positions (16-bit instruction word)
    localparam int unsigned c_OPC_MSB = 15;
    localparam int unsigned c_OPC_LSB = 12;
    localparam int unsigned c_RA_MSB  = 11;
    localparam int unsigned c_RA_LSB  = 9;
    localparam int unsigned c_RB_MSB  = 8;
    localparam int unsigned c_RB_LSB  = 6;
    localparam int unsigned c_IMM_MSB = 7;
    localparam int unsigned c_IMM_LSB = 0;

    // Opcodes; every value not listed here executes as a NOP
    localparam logic [3:0] c_OP_LI   = 4'h1;
    localparam logic [3:0] c_OP_ADD  = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_BEQZ = 4'h5;
    localparam logic [3:0] c_OP_JMP  = 4'h6;
    localparam logic [3:0] c_OP_HALT = 4'hE;
    localparam logic [3:0] c_OP_OUT  = 4'hF;

    // Core FSM
    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_OUT_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

endpackage : step_core_pkg
`default_nettype wire

// File: rtl/step_core_regfile.sv
`default_nettype none
// ============================================================================
// Module      : step_core_regfile
// Description : 8 x DATA_W register file, two combinational read ports and
//               one synchronous write port; synchronous reset clears all
//               entries to zero.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               ra_addr_i/ra_data_o - read port A
//               rb_addr_i/rb_data_o - read port B
//               we_i, waddr_i, wdata_i - write port (captured at clk edge)
// Revision    : 1.0 - initial release
// ============================================================================
module step_core_regfile
    import step_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_REG_AW-1:0] ra_addr_i,
    input  logic [c_REG_AW-1:0] rb_addr_i,
    output logic [DATA_W-1:0]   ra_data_o,
    output logic [DATA_W-1:0]   rb_data_o,
    input  logic                we_i,
    input  logic [c_REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0]   wdata_i
);

    logic [DATA_W-1:0] regs_q [c_NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(c_NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-write value, so ra == rb in ALU ops uses old data
    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];

endmodule : step_core_regfile
`default_nettype wire

// File: rtl/step_core.sv
`default_nettype none
// ============================================================================
// Module      : step_core
// Description : Paced multi-cycle 16-bit-instruction processor. Each
//               instruction spends TICK_DIV cycles in WAIT, then FETCH and
//               EXEC. OUT results leave on a valid/ready port; the core
//               stalls in OUT_WAIT until the result is accepted.
// Options     : STEP_CORE_SINGLE_STEP_EN - adds input `step`; WAIT then
//               advances on `step` instead of the tick counter.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               step           - single-step request (option only)
//               instruction    - program word at `address`
//               address        - program counter
//               result         - last OUT value
//               result_valid   - `result` not yet consumed
//               result_ready   - consumer accepts `result`
//               halted         - core stopped by HALT
// Revision    : 1.0 - initial release
// ============================================================================
module step_core
    import step_core_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 3,
    parameter int TICK_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
`ifdef STEP_CORE_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [15:0]       instruction,
    output logic [PC_W-1:0]   address,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              halted
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tick_q, tick_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;

    // Decoded fields of the latched instruction
    logic [3:0]          w_opcode;
    logic [c_REG_AW-1:0] w_ra;
    logic [c_REG_AW-1:0] w_rb;
    logic [7:0]          w_imm;

    assign w_opcode = ir_q[c_OPC_MSB:c_OPC_LSB];
    assign w_ra     = ir_q[c_RA_MSB:c_RA_LSB];
    assign w_rb     = ir_q[c_RB_MSB:c_RB_LSB];
    assign w_imm    = ir_q[c_IMM_MSB:c_IMM_LSB];

    logic [DATA_W-1:0] w_ra_data;
    logic [DATA_W-1:0] w_rb_data;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;

    step_core_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .ra_addr_i (w_ra),
        .rb_addr_i (w_rb),
        .ra_data_o (w_ra_data),
        .rb_data_o (w_rb_data),
        .we_i      (w_rf_we),
        .waddr_i   (w_ra),
        .wdata_i   (w_rf_wdata)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = '0;       // counter only runs while in WAIT
        pc_d       = pc_q;
        ir_d       = ir_q;
        result_d   = result_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        w_rf_we    = 1'b0;
        w_rf_wdata = '0;

        case (state_q)
            ST_WAIT: begin
`ifdef STEP_CORE_SINGLE_STEP_EN
                if (step) begin
                    state_d = ST_FETCH;
                end
`else
                if (tick_q == c_TICK_LAST) begin
                    state_d = ST_FETCH;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
`endif
            end

            ST_FETCH: begin
                ir_d    = instruction;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = ST_WAIT;
                pc_d    = pc_q + PC_W'(1);
                case (w_opcode)
                    c_OP_LI: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = DATA_W'(w_imm);
                    end
                    c_OP_ADD: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_ra_data + w_rb_data;
                    end
                    c_OP_SUB: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_ra_data - w_rb_data;
                    end
                    c_OP_AND: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_ra_data & w_rb_data;
                    end
                    c_OP_BEQZ: begin
                        if (w_ra_data == '0) begin
                            pc_d = PC_W'(w_imm);
                        end
                    end
                    c_OP_JMP: begin
                        pc_d = PC_W'(w_imm);
                    end
                    c_OP_HALT: begin
                        pc_d     = pc_q;   // address frozen at the HALT word
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    c_OP_OUT: begin
                        // PC advances only once the result is accepted
                        pc_d     = pc_q;
                        result_d = w_ra_data;
                        valid_d  = 1'b1;
                        state_d  = ST_OUT_WAIT;
                    end
                    default: begin
                        // NOP: just advance
                    end
                endcase
            end

            ST_OUT_WAIT: begin
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_WAIT;
                end
            end

            ST_HALT: begin
                // terminal until reset
            end

            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_WAIT;
            tick_q   <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign address      = pc_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign halted       = halted_q;

endmodule : step_core
`default_nettype wire

// File: tb/tb_step_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_core
// Description : Self-checking bench for step_core (TICK_DIV=4, DATA_W=16,
//               PC_W=3). An instruction-level model of the program pushes
//               expected OUT values and PC trace into queues; a monitor
//               pops and compares on every handshake and address change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_core;

    localparam int DATA_W   = 16;
    localparam int PC_W     = 3;
    localparam int TICK_DIV = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              result_ready = 1'b0;
    logic [15:0]       instruction;
    logic [PC_W-1:0]   address;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              halted;

    logic [15:0] rom [8];
    assign instruction = rom[address];

    always #5 clk = ~clk;

    step_core #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .address      (address),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .halted       (halted)
    );

    int total = 0;
    int bad   = 0;
    int exp_out [$];
    int exp_pc  [$];
    int model_halt_pc;
    bit model_halted;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] f_li(input int ra, input int imm);
        logic [2:0] r;
        logic [7:0] i;
        r = 3'(ra);
        i = 8'(imm);
        return {4'h1, r, 1'b0, i};
    endfunction

    function automatic logic [15:0] f_rr(input logic [3:0] op, input int ra, input int rb);
        logic [2:0] a;
        logic [2:0] b;
        a = 3'(ra);
        b = 3'(rb);
        return {op, a, b, 6'h00};
    endfunction

    // Instruction-level reference: executes the ROM program directly.
    task automatic model_run(input int max_steps);
        int regs [8];
        int pc, nxt, op, ra, rb, imm;
        logic [15:0] w;
        for (int i = 0; i < 8; i++) regs[i] = 0;
        pc = 0;
        model_halted  = 1'b0;
        model_halt_pc = 0;
        for (int s = 0; s < max_steps; s++) begin
            w   = rom[pc];
            op  = int'(w[15:12]);
            ra  = int'(w[11:9]);
            rb  = int'(w[8:6]);
            imm = int'(w[7:0]);
            nxt = (pc + 1) % 8;
            case (op)
                1:  regs[ra] = imm;
                2:  regs[ra] = (regs[ra] + regs[rb]) % 65536;
                3:  regs[ra] = (regs[ra] - regs[rb] + 65536) % 65536;
                4:  regs[ra] = regs[ra] & regs[rb];
                5:  if (regs[ra] == 0) nxt = imm % 8;
                6:  nxt = imm % 8;
                14: begin
                    model_halted  = 1'b1;
                    model_halt_pc = pc;
                end
                15: exp_out.push_back(regs[ra]);
                default: ;
            endcase
            if (model_halted) break;
            exp_pc.push_back(nxt);
            pc = nxt;
        end
    endtask

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin
        logic [PC_W-1:0] prev_addr;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_addr = '0;
            end else begin
                if (result_valid && result_ready) begin
                    if (exp_out.size() == 0) begin
                        chk("out_unexpected", 32'(result), 32'hFFFF_FFFF);
                    end else begin
                        chk("out_value", 32'(result), 32'(exp_out.pop_front()));
                    end
                end
                if (address !== prev_addr) begin
                    if (exp_pc.size() == 0) begin
                        chk("pc_unexpected", 32'(address), 32'hFFFF_FFFF);
                    end else begin
                        chk("pc_trace", 32'(address), 32'(exp_pc.pop_front()));
                    end
                    prev_addr = address;
                end
            end
        end
    end

    task automatic begin_reset();
        rst          = 1'b1;
        result_ready = 1'b0;
        cyc();
        cyc();
        exp_out.delete();
        exp_pc.delete();
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 8; i++) rom[i] = w;
    endtask

    task automatic wait_addr(input logic [PC_W-1:0] target, input int budget, output int n);
        n = 0;
        while (address !== target && n < budget + 1) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, 32'(result_valid), 32'h1);
    endtask

    task automatic run_to_halt(input int budget, input bit rnd);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            cyc();
            if (rnd) result_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        chk("halted", 32'(halted), 32'h1);
    endtask

    task automatic check_end();
        chk("halt_pc", 32'(address), 32'(model_halt_pc));
        chk("out_drained", 32'(exp_out.size()), 32'h0);
        chk("pc_drained", 32'(exp_pc.size()), 32'h0);
    endtask

    initial begin
        int n, vc, viol;
        logic [2:0] ra, rb, tgt;
        logic [7:0] imm;
        logic [3:0] nop_ops [8];
        nop_ops = '{4'h0, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
        fill_rom(16'h0000);

        // Reset values, pacing and basic ADD/OUT with ready held high
        begin_reset();
        chk("rst_address", 32'(address), 32'h0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_valid", 32'(result_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        fill_rom(16'hE000);
        rom[0] = f_li(1, 5);
        rom[1] = f_li(2, 7);
        rom[2] = f_rr(4'h2, 1, 2);
        rom[3] = f_rr(4'hF, 1, 0);
        model_run(20);
        result_ready = 1'b1;
        rst = 1'b0;
        wait_addr(3'd1, 20, n);
        chk("first_step_cycles", 32'(n), 32'd6);
        wait_addr(3'd2, 20, n);
        chk("step_period_1", 32'(n), 32'd6);
        wait_addr(3'd3, 20, n);
        chk("step_period_2", 32'(n), 32'd6);
        vc = 0;
        n  = 0;
        while (address !== 3'd4 && n < 20) begin
            cyc();
            n++;
            if (result_valid === 1'b1) begin
                vc++;
                chk("add_result", 32'(result), 32'h000C);
            end
        end
        chk("valid_one_cycle", 32'(vc), 32'd1);
        run_to_halt(50, 1'b0);
        check_end();

        // Back-pressure: ready low for 10 cycles after valid
        begin_reset();
        model_run(20);
        rst = 1'b0;
        wait_valid("stall_valid_seen", 60);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall_valid", 32'(result_valid), 32'h1);
            chk("stall_result", 32'(result), 32'h000C);
            chk("stall_address", 32'(address), 32'h3);
        end
        result_ready = 1'b1;
        cyc();
        chk("stall_release_addr", 32'(address), 32'h4);
        chk("stall_release_valid", 32'(result_valid), 32'h0);
        chk("result_held", 32'(result), 32'h000C);
        run_to_halt(50, 1'b0);
        check_end();

        // SUB wraps below zero
        begin_reset();
        fill_rom(16'hE000);
        rom[0] = f_li(1, 0);
        rom[1] = f_li(2, 1);
        rom[2] = f_rr(4'h3, 1, 2);
        rom[3] = f_rr(4'hF, 1, 0);
        model_run(20);
        result_ready = 1'b1;
        rst = 1'b0;
        wait_valid("sub_valid_seen", 60);
        chk("sub_result", 32'(result), 32'h0000_FFFF);
        run_to_halt(50, 1'b0);
        check_end();

        // Taken BEQZ then PC wrap 7 -> 0
        begin_reset();
        fill_rom(16'h0000);
        rom[0] = {4'h5, 3'd0, 1'b0, 8'd6};
        model_run(3);
        rst = 1'b0;
        n = 0;
        while (exp_pc.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        chk("wrap_trace_done", 32'(exp_pc.size()), 32'h0);
        chk("wrap_address", 32'(address), 32'h0);
        chk("wrap_not_halted", 32'(halted), 32'h0);

        // HALT freezes the address
        begin_reset();
        fill_rom(16'h0000);
        rom[2] = 16'hE000;
        model_run(20);
        rst = 1'b0;
        run_to_halt(40, 1'b0);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (address !== 3'd2 || halted !== 1'b1) viol++;
        end
        chk("halt_frozen_violations", 32'(viol), 32'h0);
        check_end();

        // Reset while stalled in OUT_WAIT
        begin_reset();
        fill_rom(16'hE000);
        rom[0] = f_li(3, 8'h5A);
        rom[1] = f_rr(4'hF, 3, 0);
        model_run(1);
        rst = 1'b0;
        wait_valid("rstmid_valid_seen", 40);
        chk("rstmid_result", 32'(result), 32'h005A);
        rst = 1'b1;
        cyc();
        chk("rstmid_valid_drop", 32'(result_valid), 32'h0);
        chk("rstmid_address", 32'(address), 32'h0);
        chk("rstmid_pc_drained", 32'(exp_pc.size()), 32'h0);

        // Randomized forward-flow programs ending in HALT
        for (int t = 0; t < 10; t++) begin
            begin_reset();
            for (int p = 0; p < 7; p++) begin
                ra  = 3'($urandom_range(0, 7));
                rb  = 3'($urandom_range(0, 7));
                imm = 8'($urandom_range(0, 255));
                tgt = 3'($urandom_range(p + 1, 7));
                case ($urandom_range(0, 7))
                    0: rom[p] = {4'h1, ra, 1'b0, imm};
                    1: rom[p] = {4'h2, ra, rb, imm[5:0]};
                    2: rom[p] = {4'h3, ra, rb, imm[5:0]};
                    3: rom[p] = {4'h4, ra, rb, imm[5:0]};
                    4: rom[p] = {4'hF, ra, rb, imm[5:0]};
                    5: rom[p] = {nop_ops[$urandom_range(0, 7)], ra, rb, imm[5:0]};
                    6: rom[p] = {4'h5, ra, 1'b0, imm[7:3], tgt};
                    default: rom[p] = {4'h6, ra, 1'b0, imm[7:3], tgt};
                endcase
            end
            rom[7] = {4'hE, 12'($urandom)};
            model_run(20);
            rst = 1'b0;
            run_to_halt(400, 1'b1);
            check_end();
        end

        result_ready = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_step_core
`default_nettype wire
